// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch front end for the 64-bit RV core. Holds the program
//   counter, drives the combinational instruction-memory read port, and
//   buffers each returned word (tagged with its PC) in a small circular
//   fetch queue. Decode drains the queue over a valid/ready handshake.
//   A redirect from execute flushes the queue and retargets the PC.
//
// Parameters
//   RESET_PC  PC value loaded on reset
//   DEPTH     fetch queue entries (power of 2, >= 2)
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous active-high reset
//   fetch_en        1 = fetching permitted; 0 = PC holds, no pushes
//   imem_addr       byte address to instruction memory (current PC)
//   imem_instr      instruction word returned combinationally for imem_addr
//   out_valid       queue head valid
//   out_ready       decode accepts the head
//   out_pc          PC of head entry
//   out_instr       instruction of head entry
//   out_exc         head carries an instruction-address-misaligned fault
//   redirect_valid  execute requests a PC change
//   redirect_pc     redirect target
//
// Build option
//   FETCH_MISALIGN_TRAP_EN  when defined, a misaligned redirect target is kept
//                           as-is, halts fetch and queues one faulting NOP.
//                           When undefined, the target is word-aligned and
//                           out_exc is tied low.
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_exc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
);

    localparam int unsigned     PTR_W     = $clog2(DEPTH);
    localparam int unsigned     CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

    logic [63:0]      r_pc;
    logic [63:0]      r_q_pc    [DEPTH];
    logic [31:0]      r_q_instr [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_halted;
    logic             r_trap_pend;

    logic [63:0]      w_redir_target;
    logic             w_redir_misaligned;
    logic             w_pop;
    logic             w_room;
    logic             w_fetch_push;
    logic             w_trap_push;
    logic             w_push;
    logic [31:0]      w_push_instr;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic [DEPTH-1:0] r_q_exc;

    assign w_redir_target     = redirect_pc;
    assign w_redir_misaligned = (redirect_pc[1:0] != 2'b00);
`else
    // Masking (rather than slicing) keeps every bit of redirect_pc in use.
    assign w_redir_target     = redirect_pc & ~64'h3;
    assign w_redir_misaligned = 1'b0;
`endif

    assign w_pop  = out_valid & out_ready;
    // A pop in the same cycle frees the slot being written, so a full queue
    // can still accept a push.
    assign w_room = (r_count < FULL_CNT) | w_pop;

    assign w_fetch_push = fetch_en & ~redirect_valid & ~r_halted & w_room;
    // The faulting NOP is pushed once, the cycle after a misaligned redirect,
    // even though normal fetching is halted.
    assign w_trap_push  = fetch_en & ~redirect_valid & r_trap_pend & w_room;
    assign w_push       = w_fetch_push | w_trap_push;
    assign w_push_instr = w_trap_push ? NOP_INSTR : imem_instr;

    assign imem_addr = r_pc;
    assign out_valid = (r_count != '0);
    assign out_pc    = r_q_pc[r_head];
    assign out_instr = r_q_instr[r_head];
`ifdef FETCH_MISALIGN_TRAP_EN
    assign out_exc   = r_q_exc[r_head];
`else
    assign out_exc   = 1'b0;
`endif

    // PC and halt state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_halted    <= 1'b0;
            r_trap_pend <= 1'b0;
        end else if (redirect_valid) begin
            r_pc        <= w_redir_target;
            r_halted    <= w_redir_misaligned;
            r_trap_pend <= w_redir_misaligned;
        end else begin
            if (w_fetch_push) begin
                r_pc <= r_pc + 64'd4;
            end
            if (w_trap_push) begin
                r_trap_pend <= 1'b0;
            end
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (redirect_valid) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_q_pc[i]    <= '0;
                r_q_instr[i] <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
                r_q_exc[i]   <= 1'b0;
`endif
            end
        end else if (w_push) begin
            r_q_pc[r_tail]    <= r_pc;
            r_q_instr[r_tail] <= w_push_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_q_exc[r_tail]   <= w_trap_push;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A combinational memory model answers
//   imem_addr. Expected entries (PC, instruction, fault flag) are queued in
//   fetch order whenever a new fetch stream starts (reset release or
//   redirect) and are popped/compared on every head handshake. Directed
//   checks cover reset state, latency, back-pressure, redirect, wrap,
//   fetch_en stall and misaligned redirects.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_en = 1'b0;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_exc;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic [63:0] frozen_addr;

    fetch_unit #(
        .RESET_PC (64'h0),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_exc        (out_exc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h0:   mem_word = 32'h0031_00B3;
            64'h4:   mem_word = 32'h4062_8233;
            64'h20:  mem_word = 32'h01BD_2CB3;
            default: mem_word = a[31:0] ^ a[63:32] ^ 32'h5A5A_0003;
        endcase
    endfunction

    assign imem_instr = mem_word(imem_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_stream(input logic [63:0] start, input int n);
        logic [63:0] pc;
        exp_t e;
        pc = start;
        for (int i = 0; i < n; i++) begin
            e.pc    = pc;
            e.instr = mem_word(pc);
            e.exc   = 1'b0;
            exp_q.push_back(e);
            pc = pc + 64'd4;
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: every completed handshake must match the next expected entry.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", {32'h0, out_instr, 31'h0, out_exc} ^ out_pc, 64'hDEAD);
                check("pop_extra_pc", out_pc, 64'hFFFF_FFFF_DEAD_BEEF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pop_pc", out_pc, e.pc);
                check("pop_instr", {32'h0, out_instr}, {32'h0, e.instr});
                check("pop_exc", {63'h0, out_exc}, {63'h0, e.exc});
            end
        end
    end

    initial begin
        // ---- Reset state, applied asynchronously -----------------------
        #1 reset = 1'b1;
        #1;
        check("rst_addr", imem_addr, 64'h0);
        check("rst_valid", {63'h0, out_valid}, 64'h0);
        check("rst_pc", out_pc, 64'h0);
        check("rst_instr", {32'h0, out_instr}, 64'h0);
        check("rst_exc", {63'h0, out_exc}, 64'h0);
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        cyc(2);

        // ---- 1: latency and streaming ----------------------------------
        reset = 1'b0;
        push_stream(64'h0, 40);
        check("t1_valid_c0", {63'h0, out_valid}, 64'h0);
        cyc(1);
        check("t1_valid_c1", {63'h0, out_valid}, 64'h1);
        check("t1_pc_c1", out_pc, 64'h0);
        check("t1_instr_c1", {32'h0, out_instr}, 64'h0031_00B3);
        check("t1_addr_c1", imem_addr, 64'h4);
        cyc(1);
        check("t1_pc_c2", out_pc, 64'h4);
        check("t1_instr_c2", {32'h0, out_instr}, 64'h4062_8233);
        cyc(6);
        check("t1_pc_c8", out_pc, 64'h1C);

        // ---- 2: back-pressure saturates the queue ----------------------
        reset = 1'b1;
        out_ready = 1'b0;
        exp_q.delete();
        cyc(1);
        reset = 1'b0;
        push_stream(64'h0, 40);
        cyc(5);
        check("t2_addr_full", imem_addr, 64'h8);
        check("t2_pc_full", out_pc, 64'h0);
        check("t2_valid_full", {63'h0, out_valid}, 64'h1);
        out_ready = 1'b1;
        cyc(6);

        // ---- 3: redirect from a full queue -----------------------------
        reset = 1'b1;
        out_ready = 1'b0;
        exp_q.delete();
        cyc(1);
        reset = 1'b0;
        push_stream(64'h0, 2);
        cyc(3);
        check("t3_pc_full", out_pc, 64'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h20;
        cyc(1);
        redirect_valid = 1'b0;
        exp_q.delete();
        push_stream(64'h20, 40);
        check("t3_valid_flush", {63'h0, out_valid}, 64'h0);
        check("t3_addr_target", imem_addr, 64'h20);
        out_ready = 1'b1;
        cyc(1);
        check("t3_valid_tgt", {63'h0, out_valid}, 64'h1);
        check("t3_pc_tgt", out_pc, 64'h20);
        check("t3_instr_tgt", {32'h0, out_instr}, 64'h01BD_2CB3);
        cyc(4);

        // ---- 4: asynchronous reset mid-stream --------------------------
        reset = 1'b1;
        exp_q.delete();
        cyc(1);
        reset = 1'b0;
        push_stream(64'h0, 40);
        cyc(5);
        check("t4_addr_mid", imem_addr, 64'h14);
        check("t4_valid_mid", {63'h0, out_valid}, 64'h1);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("t4_valid_async", {63'h0, out_valid}, 64'h0);
        check("t4_pc_async", out_pc, 64'h0);
        check("t4_addr_async", imem_addr, 64'h0);
        cyc(1);
        reset = 1'b0;
        push_stream(64'h0, 40);
        cyc(1);
        check("t4_pc_restart", out_pc, 64'h0);
        cyc(3);

        // ---- 5: PC wrap, then fetch_en stall ---------------------------
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc(1);
        redirect_valid = 1'b0;
        exp_q.delete();
        push_stream(64'hFFFF_FFFF_FFFF_FFFC, 40);
        check("t5_valid_flush", {63'h0, out_valid}, 64'h0);
        cyc(1);
        check("t5_pc_top", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("t5_addr_wrap", imem_addr, 64'h0);
        cyc(1);
        check("t5_pc_wrap", out_pc, 64'h0);
        cyc(2);
        fetch_en = 1'b0;
        frozen_addr = imem_addr;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("t5_addr_frozen", imem_addr, frozen_addr);
        end
        check("t5_valid_drained", {63'h0, out_valid}, 64'h0);
        fetch_en = 1'b1;
        cyc(6);

        // ---- 6: misaligned redirect ------------------------------------
        redirect_valid = 1'b1;
        redirect_pc    = 64'h22;
        cyc(1);
        redirect_valid = 1'b0;
        exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
        begin
            exp_t e;
            e.pc = 64'h22;
            e.instr = 32'h0000_0013;
            e.exc = 1'b1;
            exp_q.push_back(e);
        end
`else
        push_stream(64'h20, 40);
`endif
        check("t6_valid_flush", {63'h0, out_valid}, 64'h0);
        cyc(1);
        check("t6_valid_head", {63'h0, out_valid}, 64'h1);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("t6_pc_trap", out_pc, 64'h22);
        check("t6_instr_trap", {32'h0, out_instr}, 64'h13);
        check("t6_exc_trap", {63'h0, out_exc}, 64'h1);
        check("t6_addr_hold", imem_addr, 64'h22);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            check("t6_valid_halted", {63'h0, out_valid}, 64'h0);
        end
`else
        check("t6_pc_aligned", out_pc, 64'h20);
        check("t6_exc_aligned", {63'h0, out_exc}, 64'h0);
        check("t6_instr_aligned", {32'h0, out_instr}, 64'h01BD_2CB3);
        cyc(4);
`endif
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        cyc(1);
        redirect_valid = 1'b0;
        exp_q.delete();
        push_stream(64'h40, 40);
        cyc(1);
        check("t6_pc_resume", out_pc, 64'h40);
        check("t6_exc_resume", {63'h0, out_exc}, 64'h0);
        cyc(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end for the 64-bit RV core. It holds the program counter and drives the combinational instruction-memory read port. Each returned word is captured, tagged with its PC, in a small fetch queue. Fetched instructions are handed to decode over a valid/ready handshake, and branch/jump redirects from execute flush and retarget the queue.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
DEPTH, 2, fetch queue entries; power of 2, >= 2.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
fetch_en  input  1  1 = fetching permitted; 0 = PC holds and no pushes occur.
imem_addr  output  64  byte address to instruction memory; equals current PC (combinational from PC register).
imem_instr  input  32  instruction word returned combinationally for imem_addr.
out_valid  output  1  queue head valid.
out_ready  input  1  decode accepts head.
out_pc  output  64  PC of head entry.
out_instr  output  32  instruction of head entry.
out_exc  output  1  head carries instruction-address-misaligned fault (see Optional Feature).
redirect_valid  input  1  execute requests PC change.
redirect_pc  input  64  redirect target.

Behaviour:
- Reset (async, immediate, no clock edge needed):
  - PC = RESET_PC, queue count = 0, all queue storage = 0.
  - out_valid = 0, out_pc = 0, out_instr = 0, out_exc = 0.
  - imem_addr = RESET_PC.
- pop = out_valid & out_ready. A transfer completes on the clock edge where pop is 1.
- push = fetch_en & ~redirect_valid & ~halted & (count < DEPTH | pop).
  - On push, {PC, imem_instr, 0} is written at the tail and PC <= PC + 4.
  - PC arithmetic is modulo 2^64; 0xFFFF_FFFF_FFFF_FFFC + 4 = 0.
- Full with simultaneous pop: push is allowed and count is unchanged.
- Empty: no pop is possible (out_valid = 0); push alone sets count to 1.
- out_valid = (count != 0). out_pc, out_instr and out_exc come from the head entry (registered storage, not from imem_instr).
- Latency: the word at PC appears on the outputs the cycle after imem_addr = PC is sampled. With out_ready held at 1, throughput is one instruction per cycle.
- Redirect has highest priority:
  - count <= 0 and PC <= target.
  - No push occurs in the redirect cycle.
  - A head handshake in the same cycle counts as completed.
  - out_valid = 0 in the next cycle; the target instruction appears one cycle later.
- fetch_en = 0: PC holds, no push; pops continue until the queue drains.
- Entries leave in strict fetch order, with no duplicates and no gaps.

Optional Feature:
Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc[1:0] != 0 loads PC = redirect_pc unmodified and sets halted.
  - On the next cycle it pushes one entry: out_pc = redirect_pc, out_instr = 32'h0000_0013 (NOP), out_exc = 1.
  - No further pushes until the next redirect, which clears halted.
  - Reset clears halted.
- Undefined:
  - redirect_pc[1:0] is forced to 2'b00.
  - halted is never set and out_exc is tied 0.

Test Plan:
1. Memory word 0 = 0x003100B3, word 1 = 0x40628233. Release reset with fetch_en = 1, out_ready = 1 -> cycle 1 out_pc = 0 / out_instr = 0x003100B3, cycle 2 out_pc = 4 / out_instr = 0x40628233, then one new PC per cycle.
2. Hold out_ready = 0 for 5 cycles after reset -> count saturates at 2, imem_addr holds 0x8, out_pc stays 0. Release -> heads 0x0, 0x4, 0x8, 0xC in order, none repeated.
3. Queue full with heads 0x0 and 0x4; redirect_valid = 1 with redirect_pc = 0x20 -> next cycle out_valid = 0. The following cycle out_pc = 0x20 and out_instr = memory word 8 (0x01BD2CB3).
4. Assert reset asynchronously mid-stream at PC 0x14 with out_valid = 1 -> out_valid = 0, out_pc = 0, imem_addr = RESET_PC before any clock edge. After release, fetch restarts at RESET_PC.
5. Redirect to 0xFFFF_FFFF_FFFF_FFFC -> head at that PC, then the next head has out_pc = 0 (wrap). Separately, fetch_en = 0 for 3 cycles -> PC frozen, queue drains, resumes without gap.
6. Redirect to 0x22 -> with FETCH_MISALIGN_TRAP_EN: one head with out_pc = 0x22, out_instr = 0x00000013, out_exc = 1, then out_valid = 0 until a redirect to 0x40 resumes fetching. Without the macro: head out_pc = 0x20, out_exc = 0.
